div_arbiter: RTL and testbench

- Shares one sequential divider (4-bit dividend/divisor, start/busy/ready handshake) among N_REQ requesters.
- Round-robin arbitration picks one request and latches its operands. It issues a one-cycle start to the divider, waits for completion, and returns quotient/remainder with a one-cycle done pulse to the winner.
- Sits between client blocks and the divider. Divide-by-zero and divider hang are reported without stalling other requesters.

---
 rtl/div_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_div_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_arbiter.sv
// Round-robin front end that shares one sequential divider among N_REQ clients.
// Reports divide-by-zero and divider hang as error responses so no client stalls.
module div_arbiter #(
    parameter int N_REQ   = 4,
    parameter int W       = 4,
    parameter int RW      = 3,
    parameter int TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               clear,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ*W-1:0] req_a,
    input  logic [N_REQ*W-1:0] req_b,
    output logic [N_REQ-1:0]   gnt,
    output logic [N_REQ-1:0]   done,
    output logic [W-1:0]       res_q,
    output logic [RW-1:0]      res_r,
    output logic               res_err,
    output logic               arb_busy,
    output logic [W-1:0]       div_a,
    output logic [W-1:0]       div_b,
    output logic               div_start,
    input  logic [W-1:0]       div_q,
    input  logic [RW-1:0]      div_r,
    input  logic               div_busy,
    input  logic               div_ready
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t            state_r, state_s;
    logic [IW-1:0]     ptr_r, ptr_s;
    logic [IW-1:0]     win_r, win_s;
    logic [CW-1:0]     cnt_r, cnt_s, cnt_inc_s;
    logic [IW:0]       pick_s;
    logic [IW-1:0]     pick_idx_s;
    logic [N_REQ-1:0]  pick_oh_s, win_oh_s;
    logic [W-1:0]      sel_a_s, sel_b_s;
    logic [N_REQ-1:0]  gnt_s, done_s;
    logic [W-1:0]      res_q_s, div_a_s, div_b_s;
    logic [RW-1:0]     res_r_s;
    logic              res_err_s, arb_busy_s, div_start_s;

    // Returns {found, index} of the first set request at or above ptr, wrapping.
    function automatic logic [IW:0] rr_pick(input logic [N_REQ-1:0] r,
                                            input logic [IW-1:0]    p);
        logic [IW:0] res;
        int          idx;
        res = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = (int'(p) + k) % N_REQ;
            res = r[idx] ? {1'b1, IW'(idx)} : res;
        end
        return res;
    endfunction

    // Candidate winner and its operands, only consumed in IDLE.
    always_comb begin
        pick_s     = rr_pick(req, ptr_r);
        pick_idx_s = pick_s[IW-1:0];
        pick_oh_s  = ONE_HOT0 << pick_idx_s;
        win_oh_s   = ONE_HOT0 << win_r;
        sel_a_s    = req_a[pick_idx_s*W +: W];
        sel_b_s    = req_b[pick_idx_s*W +: W];
        cnt_inc_s  = cnt_r + CW'(1);
    end

    // Next-state and next-output logic of the transaction FSM.
    always_comb begin
        state_s     = state_r;
        ptr_s       = ptr_r;
        win_s       = win_r;
        cnt_s       = cnt_r;
        gnt_s       = gnt;
        done_s      = '0;
        res_q_s     = res_q;
        res_r_s     = res_r;
        res_err_s   = res_err;
        div_a_s     = div_a;
        div_b_s     = div_b;
        div_start_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (pick_s[IW]) begin
                    win_s   = pick_idx_s;
                    gnt_s   = pick_oh_s;
                    div_a_s = sel_a_s;
                    div_b_s = sel_b_s;
                    // A zero divisor never reaches the divider; answer straight away.
                    if (sel_b_s == {W{1'b0}}) begin
                        state_s   = ST_RESP;
                        done_s    = pick_oh_s;
                        res_err_s = 1'b1;
                        res_q_s   = {W{1'b1}};
                        res_r_s   = {RW{1'b0}};
                    end else begin
                        state_s     = ST_ISSUE;
                        div_start_s = 1'b1;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                cnt_s   = {CW{1'b0}};
                state_s = ST_WAIT;
            end
            ST_WAIT: begin
                if (div_ready && !div_busy) begin
                    state_s   = ST_RESP;
                    done_s    = win_oh_s;
                    res_q_s   = div_q;
                    res_r_s   = div_r;
                    res_err_s = 1'b0;
                end else if (cnt_inc_s == CW'(TIMEOUT)) begin
                    state_s   = ST_RESP;
                    done_s    = win_oh_s;
                    res_q_s   = {W{1'b0}};
                    res_r_s   = {RW{1'b0}};
                    res_err_s = 1'b1;
                end else begin
                    cnt_s = cnt_inc_s;
                end
            end
            ST_RESP: begin
                gnt_s   = '0;
                state_s = ST_IDLE;
                if (win_r == IW'(N_REQ - 1)) begin
                    ptr_s = {IW{1'b0}};
                end else begin
                    ptr_s = win_r + IW'(1);
                end
            end
            default: begin
                state_s = ST_IDLE;
                gnt_s   = '0;
            end
        endcase
        arb_busy_s = (state_s != ST_IDLE);
    end

    // State and registered outputs; clear aborts any transaction silently.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state_r   <= ST_IDLE;
            ptr_r     <= {IW{1'b0}};
            win_r     <= {IW{1'b0}};
            cnt_r     <= {CW{1'b0}};
            gnt       <= '0;
            done      <= '0;
            res_q     <= {W{1'b0}};
            res_r     <= {RW{1'b0}};
            res_err   <= 1'b0;
            arb_busy  <= 1'b0;
            div_a     <= {W{1'b0}};
            div_b     <= {W{1'b0}};
            div_start <= 1'b0;
        end else begin
            state_r   <= state_s;
            ptr_r     <= ptr_s;
            win_r     <= win_s;
            cnt_r     <= cnt_s;
            gnt       <= gnt_s;
            done      <= done_s;
            res_q     <= res_q_s;
            res_r     <= res_r_s;
            res_err   <= res_err_s;
            arb_busy  <= arb_busy_s;
            div_a     <= div_a_s;
            div_b     <= div_b_s;
            div_start <= div_start_s;
        end
    end

endmodule

// File: tb/tb_div_arbiter.sv
// Bench for div_arbiter: behavioural divider, transaction-level timeline model,
// directed scenarios pinned by literal values, then a randomized run.
module tb_div_arbiter;

    localparam int N    = 4;
    localparam int W    = 4;
    localparam int RW   = 3;
    localparam int TO   = 15;
    localparam int DLAT = 4;

    logic           clk   = 1'b0;
    logic           clear = 1'b0;
    logic [N-1:0]   req   = '0;
    logic [N*W-1:0] req_a = '0;
    logic [N*W-1:0] req_b = '0;
    logic [N-1:0]   gnt, done;
    logic [W-1:0]   res_q, div_a, div_b, div_q;
    logic [RW-1:0]  res_r, div_r;
    logic           res_err, arb_busy, div_start, div_busy, div_ready;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    div_arbiter #(.N_REQ(N), .W(W), .RW(RW), .TIMEOUT(TO)) dut (
        .clk(clk), .clear(clear), .req(req), .req_a(req_a), .req_b(req_b),
        .gnt(gnt), .done(done), .res_q(res_q), .res_r(res_r), .res_err(res_err),
        .arb_busy(arb_busy), .div_a(div_a), .div_b(div_b), .div_start(div_start),
        .div_q(div_q), .div_r(div_r), .div_busy(div_busy), .div_ready(div_ready)
    );

    // Divider: DLAT cycles from start to ready, or stuck busy while hang is set.
    bit hang = 1'b0;
    int dleft;
    always @(posedge clk or negedge clear) begin
        if (!clear) begin
            div_busy <= 1'b0; div_ready <= 1'b0; div_q <= '0; div_r <= '0; dleft <= 0;
        end else if (div_start) begin
            div_busy <= 1'b1; div_ready <= 1'b0; dleft <= DLAT - 1;
        end else if (div_busy && !hang) begin
            if (dleft == 1) begin
                div_busy  <= 1'b0;
                div_ready <= 1'b1;
                div_q     <= (div_b == 0) ? '1 : div_a / div_b;
                div_r     <= (div_b == 0) ? '0 : RW'(div_a % div_b);
            end else begin
                dleft <= dleft - 1;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] oh(input int i);
        logic [N-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // Model: one transaction = winner, operands, selection cycle, response cycle.
    int           cyc = 0;
    bit           m_act = 1'b0;
    int           m_w = 0, m_sel = 0, m_resp = 0, m_ptr = 0;
    logic [W-1:0] m_a, m_b, m_q;
    logic [RW-1:0] m_r;
    logic         m_err;

    // Observations of the DUT used by the literal checks.
    int           lg_idx[$], lg_q[$], lg_r[$], lg_err[$], lg_cyc[$];
    int           n_start = 0, st_cyc = 0, st_a = 0, st_b = 0;

    function automatic logic [N-1:0] exp_done_now();
        return (m_act && cyc == m_resp) ? oh(m_w) : '0;
    endfunction

    function automatic bit model_busy();
        return m_act && cyc <= m_resp;
    endfunction

    initial begin : compare
        logic [N-1:0] e_gnt, e_done;
        bit           e_txn, e_start;
        int           w, j;
        forever begin
            @(negedge clk);
            if (clear !== 1'b1) begin
                chk("rst_gnt", 32'(gnt), 32'd0);
                chk("rst_done", 32'(done), 32'd0);
                chk("rst_start", 32'(div_start), 32'd0);
                chk("rst_busy", 32'(arb_busy), 32'd0);
                chk("rst_res", {res_q, res_r, res_err}, 32'd0);
                chk("rst_div_ab", {div_a, div_b}, 32'd0);
                m_act = 1'b0;
                m_ptr = 0;
            end else begin
                e_txn   = model_busy();
                e_gnt   = e_txn ? oh(m_w) : '0;
                e_done  = exp_done_now();
                e_start = e_txn && cyc == m_sel && m_b != 0;
                chk("gnt", 32'(gnt), 32'(e_gnt));
                chk("done", 32'(done), 32'(e_done));
                chk("div_start", 32'(div_start), 32'(e_start));
                chk("arb_busy", 32'(arb_busy), 32'(e_txn));
                if (e_txn) begin
                    chk("div_a", 32'(div_a), 32'(m_a));
                    chk("div_b", 32'(div_b), 32'(m_b));
                end
                if (e_done != 0) begin
                    chk("res_q", 32'(res_q), 32'(m_q));
                    chk("res_r", 32'(res_r), 32'(m_r));
                    chk("res_err", 32'(res_err), 32'(m_err));
                end
                if (div_start === 1'b1) begin
                    n_start++; st_cyc = cyc; st_a = int'(div_a); st_b = int'(div_b);
                end
                if (done != 0) begin
                    j = 0;
                    for (int i = 0; i < N; i++) if (done[i]) j = i;
                    lg_idx.push_back(j); lg_q.push_back(int'(res_q));
                    lg_r.push_back(int'(res_r)); lg_err.push_back(int'(res_err));
                    lg_cyc.push_back(cyc);
                end
                // An idle cycle with pending requests selects at the coming edge.
                if (!e_txn && req != 0) begin
                    w = -1;
                    for (int k = 0; k < N; k++)
                        if (w < 0 && req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
                    m_act = 1'b1;
                    m_w   = w;
                    m_a   = req_a[w*W +: W];
                    m_b   = req_b[w*W +: W];
                    m_sel = cyc + 1;
                    m_ptr = (w + 1) % N;
                    if (m_b == 0) begin
                        m_resp = m_sel; m_err = 1'b1; m_q = 4'hF; m_r = '0;
                    end else if (hang) begin
                        m_resp = m_sel + TO + 1; m_err = 1'b1; m_q = '0; m_r = '0;
                    end else begin
                        m_resp = m_sel + DLAT + 1; m_err = 1'b0;
                        m_q = m_a / m_b; m_r = RW'(m_a % m_b);
                    end
                end
            end
            cyc++;
        end
    end

    // Requester behaviour: drop in own done cycle, optional re-raise / random traffic.
    logic [N-1:0] persist = '0;
    bit           rnd_mode = 1'b0;

    task automatic drive();
        logic [N-1:0] dn;
        dn = exp_done_now();
        for (int i = 0; i < N; i++) begin
            if (dn[i]) begin
                req[i] = 1'b0;
            end else if (!req[i]) begin
                if (persist[i]) begin
                    req[i] = 1'b1;
                end else if (rnd_mode && $urandom_range(0, 3) == 0) begin
                    req_a[i*W +: W] = 4'($urandom_range(0, 15));
                    req_b[i*W +: W] = 4'($urandom_range(0, 8));
                    req[i] = 1'b1;
                end
            end else if (rnd_mode && m_act && m_w == i && cyc >= m_sel && cyc <= m_resp
                         && $urandom_range(0, 1) == 0) begin
                req_a[i*W +: W] = 4'($urandom_range(0, 15));
                req_b[i*W +: W] = 4'($urandom_range(0, 15));
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic set_req(input int i, input int a, input int b);
        req_a[i*W +: W] = W'(a);
        req_b[i*W +: W] = W'(b);
        req[i] = 1'b1;
    endtask

    task automatic wait_dones(input int n, input int budget);
        int tgt, k;
        tgt = lg_idx.size() + n;
        k = 0;
        while (lg_idx.size() < tgt && k < budget) begin tick(); k++; end
        chk("done_within_budget", 32'(lg_idx.size() >= tgt), 32'd1);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((req != 0 || model_busy()) && k < 400) begin tick(); k++; end
        chk("drain_budget", 32'(k < 400), 32'd1);
        tick();
    endtask

    task automatic pulse_reset();
        tick();
        clear = 1'b0;
        repeat (2) tick();
        clear = 1'b1;
    endtask

    task automatic chk_log(input string nm, input int at, input int idx, input int q,
                           input int r, input int err);
        if (at < lg_idx.size()) begin
            chk({nm, "_idx"}, 32'(lg_idx[at]), 32'(idx));
            chk({nm, "_q"}, 32'(lg_q[at]), 32'(q));
            chk({nm, "_r"}, 32'(lg_r[at]), 32'(r));
            chk({nm, "_err"}, 32'(lg_err[at]), 32'(err));
        end else begin
            chk({nm, "_present"}, 32'd0, 32'd1);
        end
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int base, c0, s0, k;
        repeat (3) tick();
        chk("init_gnt", 32'(gnt), 32'd0);
        chk("init_busy", 32'(arb_busy), 32'd0);
        clear = 1'b1;

        // Single request 5/4: start one cycle after raise, done 6 cycles after raise.
        tick(); set_req(0, 5, 4); c0 = cyc; base = lg_idx.size();
        wait_dones(1, 40);
        chk_log("t1", base, 0, 1, 1, 0);
        if (lg_idx.size() > base) chk("t1_latency", 32'(lg_cyc[base] - c0), 32'd6);
        chk("t1_start_cyc", 32'(st_cyc - c0), 32'd1);
        chk("t1_div_ab", 32'({st_a[3:0], st_b[3:0]}), 32'h54);
        drain();

        // Contention from pointer 0.
        pulse_reset();
        tick(); set_req(0, 7, 3); set_req(2, 7, 4); base = lg_idx.size();
        wait_dones(2, 60);
        chk_log("t2a", base, 0, 2, 1, 0);
        chk_log("t2b", base + 1, 2, 1, 3, 0);
        drain();

        // Fairness with all requesters holding requests.
        pulse_reset();
        tick();
        set_req(0, 6, 3); set_req(1, 6, 2); set_req(2, 8, 4); set_req(3, 7, 3);
        persist = '1; base = lg_idx.size();
        wait_dones(5, 100);
        persist = '0;
        chk_log("t3_0", base, 0, 2, 0, 0);
        chk_log("t3_1", base + 1, 1, 3, 0, 0);
        chk_log("t3_2", base + 2, 2, 2, 0, 0);
        chk_log("t3_3", base + 3, 3, 2, 1, 0);
        chk_log("t3_4", base + 4, 0, 2, 0, 0);
        drain();

        // Divide by zero bypasses the divider.
        tick(); s0 = n_start; set_req(1, 9, 0); c0 = cyc; base = lg_idx.size();
        wait_dones(1, 20);
        chk_log("t4", base, 1, 15, 0, 1);
        if (lg_idx.size() > base) chk("t4_latency", 32'(lg_cyc[base] - c0), 32'd1);
        chk("t4_no_start", 32'(n_start - s0), 32'd0);
        drain();

        // Hung divider times out after TO wait cycles; the next request still works.
        hang = 1'b1;
        tick(); set_req(2, 7, 2); base = lg_idx.size();
        wait_dones(1, 60);
        chk_log("t5", base, 2, 0, 0, 1);
        if (lg_idx.size() > base) chk("t5_timeout", 32'(lg_cyc[base] - st_cyc), 32'(TO + 1));
        drain();
        hang = 1'b0;
        tick(); set_req(3, 13, 5); base = lg_idx.size();
        wait_dones(1, 40);
        chk_log("t5_next", base, 3, 2, 3, 0);
        drain();

        // Reset in WAIT: pointer returns to 0 and both pending requests complete.
        tick(); set_req(1, 8, 3);
        wait_dones(1, 40);
        drain();
        tick(); set_req(0, 11, 2); set_req(2, 12, 5); s0 = n_start;
        k = 0;
        while (n_start == s0 && k < 20) begin tick(); k++; end
        chk("t6_started", 32'(n_start - s0), 32'd1);
        tick();
        clear = 1'b0;
        #1;
        chk("t6_async_gnt", 32'(gnt), 32'd0);
        chk("t6_async_busy", 32'(arb_busy), 32'd0);
        chk("t6_async_ab", {div_a, div_b, div_start}, 32'd0);
        repeat (2) tick();
        clear = 1'b1;
        base = lg_idx.size();
        wait_dones(2, 60);
        chk_log("t6a", base, 0, 5, 1, 0);
        chk_log("t6b", base + 1, 2, 2, 2, 0);
        drain();

        // Randomized traffic against the model.
        rnd_mode = 1'b1;
        repeat (1500) tick();
        rnd_mode = 1'b0;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
